// File: rtl/cart_mem_arbiter.sv
// Arbiter for the shared cartridge memory port: the SNES CPU path has priority,
// and a host backup engine uses idle gaps. A per-access watchdog aborts hung accesses.
module cart_mem_arbiter #(
  parameter int          STARVE_LIMIT = 8,
  parameter int          TIMEOUT      = 63,
  parameter logic [23:0] BSRAM_BASE   = 24'hE00000
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [23:0] CPU_ADDR,
  input  logic [7:0]  CPU_DI,
  output logic [7:0]  CPU_DO,
  output logic        CPU_READY,
  input  logic        HOST_REQ,
  input  logic        HOST_WE,
  input  logic [19:0] HOST_ADDR,
  input  logic [7:0]  HOST_DI,
  output logic [7:0]  HOST_DO,
  output logic        HOST_ACK,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [23:0] MEM_ADDR,
  output logic [7:0]  MEM_D,
  input  logic [7:0]  MEM_Q,
  input  logic        MEM_ACK,
  output logic        ERR_TIMEOUT,
  output logic        ERR_OVERRUN,
  input  logic        CLR_ERR
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]    WDOG_MAX   = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_WAIT  = 2'd1,
    HOST_WAIT = 2'd2
  } state_t;

  state_t        state_reg;
  logic          pend_reg;
  logic          lat_we_reg;
  logic [23:0]   lat_addr_reg;
  logic [7:0]    lat_di_reg;
  logic [SW-1:0] starve_reg;
  logic [7:0]    wdog_reg;

  logic [7:0]    cpu_do_reg;
  logic          cpu_ready_reg;
  logic [7:0]    host_do_reg;
  logic          host_ack_reg;
  logic          mem_req_reg;
  logic          mem_we_reg;
  logic [23:0]   mem_addr_reg;
  logic [7:0]    mem_d_reg;
  logic          err_timeout_reg;
  logic          err_overrun_reg;

  logic          idle;
  logic          busy;
  logic          cpu_pend;
  logic          host_grant;
  logic          cpu_grant;
  logic          mem_done;
  logic          wdog_abort;
  logic          overrun;
  logic [7:0]    done_data;
  logic          iss_we;
  logic [23:0]   iss_addr;
  logic [7:0]    iss_di;
  logic [23:0]   host_addr_full;

  assign idle       = (state_reg == IDLE);
  assign busy       = (state_reg == CPU_WAIT) || (state_reg == HOST_WAIT);
  assign cpu_pend   = pend_reg | CPU_REQ;
  assign host_grant = idle && HOST_REQ && (!cpu_pend || (starve_reg == STARVE_MAX));
  assign cpu_grant  = idle && !host_grant && cpu_pend;

  // A latched request always goes out before a fresh strobe arriving the same cycle.
  assign iss_we   = pend_reg ? lat_we_reg   : CPU_WE;
  assign iss_addr = pend_reg ? lat_addr_reg : CPU_ADDR;
  assign iss_di   = pend_reg ? lat_di_reg   : CPU_DI;

  assign host_addr_full = BSRAM_BASE + {4'b0, HOST_ADDR};

  assign mem_done   = busy && (MEM_ACK || (wdog_reg == WDOG_MAX));
  assign wdog_abort = busy && !MEM_ACK && (wdog_reg == WDOG_MAX);
  assign done_data  = MEM_ACK ? MEM_Q : 8'hFF;
  assign overrun    = CPU_REQ && pend_reg && !cpu_grant;

  always_ff @(posedge MCLK) begin
    if (RST) begin
      state_reg       <= IDLE;
      pend_reg        <= 1'b0;
      lat_we_reg      <= 1'b0;
      lat_addr_reg    <= 24'h0;
      lat_di_reg      <= 8'h0;
      starve_reg      <= '0;
      wdog_reg        <= 8'h0;
      cpu_do_reg      <= 8'hFF;
      cpu_ready_reg   <= 1'b0;
      host_do_reg     <= 8'h00;
      host_ack_reg    <= 1'b0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= 24'h0;
      mem_d_reg       <= 8'h0;
      err_timeout_reg <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      mem_req_reg   <= 1'b0;
      cpu_ready_reg <= 1'b0;
      host_ack_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (host_grant) begin
            state_reg    <= HOST_WAIT;
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= HOST_WE;
            mem_addr_reg <= host_addr_full;
            mem_d_reg    <= HOST_DI;
            wdog_reg     <= 8'h0;
          end else if (cpu_grant) begin
            state_reg    <= CPU_WAIT;
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= iss_we;
            mem_addr_reg <= iss_addr;
            mem_d_reg    <= iss_di;
            wdog_reg     <= 8'h0;
          end
        end
        CPU_WAIT, HOST_WAIT: begin
          wdog_reg <= wdog_reg + 8'd1;
          if (mem_done) begin
            state_reg <= IDLE;
            if (state_reg == CPU_WAIT) begin
              cpu_ready_reg <= 1'b1;
              if (!mem_we_reg) cpu_do_reg <= done_data;
            end else begin
              host_ack_reg <= 1'b1;
              if (!mem_we_reg) host_do_reg <= done_data;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase

      // The pending slot frees at issue, so a strobe on the issue cycle refills it.
      if (CPU_REQ && (!pend_reg || cpu_grant)) begin
        lat_we_reg   <= CPU_WE;
        lat_addr_reg <= CPU_ADDR;
        lat_di_reg   <= CPU_DI;
      end
      if (cpu_grant) pend_reg <= pend_reg & CPU_REQ;
      else           pend_reg <= pend_reg | CPU_REQ;

      if (!HOST_REQ || host_grant)
        starve_reg <= '0;
      else if (cpu_grant && (starve_reg != STARVE_MAX))
        starve_reg <= starve_reg + SW'(1);

      if (wdog_abort)   err_timeout_reg <= 1'b1;
      else if (CLR_ERR) err_timeout_reg <= 1'b0;

      if (overrun)      err_overrun_reg <= 1'b1;
      else if (CLR_ERR) err_overrun_reg <= 1'b0;
    end
  end

  assign CPU_DO      = cpu_do_reg;
  assign CPU_READY   = cpu_ready_reg;
  assign HOST_DO     = host_do_reg;
  assign HOST_ACK    = host_ack_reg;
  assign MEM_REQ     = mem_req_reg;
  assign MEM_WE      = mem_we_reg;
  assign MEM_ADDR    = mem_addr_reg;
  assign MEM_D       = mem_d_reg;
  assign ERR_TIMEOUT = err_timeout_reg;
  assign ERR_OVERRUN = err_overrun_reg;

endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Shares the single cartridge memory port (ROM + BSRAM in SDRAM) between two requesters:
  - the SNES CPU path, which the LoROM/HiROM mapper drives;
  - a host backup engine that streams BSRAM to or from the SD card for save/restore.
- CPU accesses have priority.
- Host accesses fill idle gaps and carry a starvation guard.
- A per-access watchdog keeps a hung memory from locking the CPU bus.

Parameters:
- STARVE_LIMIT, 8: consecutive CPU grants allowed while the host waits; after that the host gets the next grant.
- TIMEOUT, 63: cycles after MEM_REQ without MEM_ACK before the access is aborted. Range 1..255.
- BSRAM_BASE, 24'hE00000: byte base of the BSRAM region; the host address is added to it.

Ports:
- MCLK  in  1  master clock.
- RST  in  1  synchronous reset, active-high.
- CPU_REQ  in  1  one-cycle strobe from the mapper: a cart access at the current CPU_ADDR.
- CPU_WE  in  1  1 = write; sampled with CPU_REQ.
- CPU_ADDR  in  24  byte address, already masked by the mapper.
- CPU_DI  in  8  write data.
- CPU_DO  out  8  read data; held until the next CPU completion.
- CPU_READY  out  1  one-cycle pulse when a CPU access completes.
- HOST_REQ  in  1  level request; held until HOST_ACK.
- HOST_WE  in  1  1 = write.
- HOST_ADDR  in  20  BSRAM byte offset.
- HOST_DI  in  8  write data.
- HOST_DO  out  8  read data; valid with HOST_ACK.
- HOST_ACK  out  1  one-cycle pulse when a host access completes.
- MEM_REQ  out  1  one-cycle issue strobe to the memory controller.
- MEM_WE  out  1  write enable; valid with MEM_REQ.
- MEM_ADDR  out  24  byte address; held from issue until completion.
- MEM_D  out  8  write data; held from issue until completion.
- MEM_Q  in  8  read data; valid with MEM_ACK.
- MEM_ACK  in  1  one-cycle completion pulse from the memory controller.
- ERR_TIMEOUT  out  1  sticky flag: a watchdog abort occurred.
- ERR_OVERRUN  out  1  sticky flag: a CPU request was dropped.
- CLR_ERR  in  1  clears both sticky flags.

Behaviour:
- Reset (RST high at a clock edge), from any state including mid-access:
  - state = IDLE; CPU pending flag cleared; starve counter = 0; watchdog = 0.
  - CPU_DO = 8'hFF, HOST_DO = 8'h00.
  - CPU_READY, HOST_ACK, MEM_REQ, MEM_WE = 0; MEM_ADDR = 0; MEM_D = 0.
  - ERR_TIMEOUT = ERR_OVERRUN = 0.
  - A MEM_ACK for an access issued before reset is ignored.
- CPU request latch:
  - CPU_REQ sets pending and captures {WE, ADDR, DI}.
  - CPU_REQ while pending is already set: the new request is dropped, the latched request is kept, ERR_OVERRUN is set.
  - CPU_REQ on the same cycle the latched request is issued is accepted as the new pending request (no overrun).
- States:
  - IDLE: pick a requester and issue it.
  - CPU_WAIT: a CPU access is outstanding.
  - HOST_WAIT: a host access is outstanding.
- IDLE decision, evaluated every cycle:
  - The CPU counts as pending if the pending flag is set or CPU_REQ is high this cycle.
  - Host is granted if HOST_REQ = 1 and either no CPU request is pending, or starve counter == STARVE_LIMIT.
  - Otherwise the CPU is granted if it is pending.
- Issuing a grant:
  - Registered outputs: MEM_REQ = 1 for exactly one cycle; MEM_ADDR/MEM_WE/MEM_D are loaded.
  - Host address = BSRAM_BASE + {4'b0, HOST_ADDR}, modulo 2^24 (wraps).
  - Next state is CPU_WAIT or HOST_WAIT; watchdog is cleared.
- Latency: CPU_REQ at cycle t in IDLE with no host override gives MEM_REQ high at t+1.
- Starve counter:
  - Increments on each CPU grant while HOST_REQ = 1; saturates at STARVE_LIMIT.
  - Cleared on a host grant, and whenever HOST_REQ = 0.
- CPU_WAIT / HOST_WAIT:
  - Watchdog increments each cycle.
  - MEM_ACK at cycle n:
    - CPU reads: CPU_DO = MEM_Q. CPU writes: CPU_DO keeps its previous value.
    - Host reads: HOST_DO = MEM_Q. Host writes: HOST_DO keeps its previous value.
    - CPU_READY or HOST_ACK pulses at n+1; state returns to IDLE at n+1.
    - The next MEM_REQ can occur at n+2 at the earliest.
  - The CPU pending flag clears at issue, not at completion.
- Watchdog abort:
  - Triggers when watchdog == TIMEOUT with no MEM_ACK.
  - On abort: set ERR_TIMEOUT; complete the access as if acknowledged with data 8'hFF (CPU_DO or HOST_DO = FF on reads); go to IDLE.
  - If MEM_ACK arrives on the same cycle as the watchdog match, the ACK wins and no error is flagged.
- MEM_ACK while in IDLE (stray) is ignored.
- CLR_ERR clears both sticky flags. If CLR_ERR and a new error event occur on the same cycle, the set wins.
- Only one access is ever outstanding. MEM_ADDR, MEM_WE and MEM_D are stable from issue until the cycle after completion.

Test Plan:
- CPU read 24'h008000, MEM_ACK 5 cycles after MEM_REQ with MEM_Q = 8'h5A -> MEM_REQ at t+1, CPU_READY at ACK+1, CPU_DO = 5A.
- HOST_REQ write HOST_ADDR 20'h00010, HOST_DI = 8'h33, idle CPU -> MEM_ADDR = E00010, MEM_WE = 1, MEM_D = 33, HOST_ACK once.
- HOST_REQ held, CPU_REQ every cycle the arbiter returns to IDLE, STARVE_LIMIT = 8 -> host granted after the 8th CPU grant, counter back to 0.
- CPU_REQ twice during an outstanding access -> first request served next, second dropped, ERR_OVERRUN = 1; CLR_ERR -> 0.
- No MEM_ACK, TIMEOUT = 63 -> abort 63 cycles after MEM_REQ, CPU_READY with CPU_DO = FF, ERR_TIMEOUT = 1; MEM_ACK on the match cycle instead -> no error.
- RST asserted during CPU_WAIT, late MEM_ACK after reset -> all outputs at reset values, no CPU_READY/HOST_ACK, state IDLE.
